ceespu_muldiv: RTL

Iterative 32-bit multiply/divide unit that services the ALU's multi-cycle operations. The ALU raises a start request with operands and a sub-operation. This block computes the result over 32 iterations and answers with a one-cycle `O_dataReady` pulse, which the ALU forwards as its own ready indication. It is the responder side of the ALU's multi-cycle handshake (`O_multiCycle` / `O_dataReady`).

---
 rtl/ceespu_muldiv_if.sv | 27 ++
 rtl/ceespu_muldiv.sv | 118 +++++++++++
 2 files changed

// File: rtl/ceespu_muldiv_if.sv
`default_nettype none
// ============================================================================
// ceespu_muldiv_if : ALU <-> multiply/divide unit multi-cycle handshake bus
// Revision: 1.0
// ============================================================================
interface ceespu_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             I_start;
    logic [1:0]       I_op;
    logic [WIDTH-1:0] I_dataA;
    logic [WIDTH-1:0] I_dataB;
    logic             O_busy;
    logic             O_dataReady;
    logic [WIDTH-1:0] O_dataResult;

    modport master (
        output I_start, I_op, I_dataA, I_dataB,
        input  O_busy, O_dataReady, O_dataResult
    );

    modport slave (
        input  I_start, I_op, I_dataA, I_dataB,
        output O_busy, O_dataReady, O_dataResult
    );
endinterface
`default_nettype wire

// File: rtl/ceespu_muldiv.sv
`default_nettype none
// ============================================================================
// ceespu_muldiv : iterative unsigned shift-add multiplier / restoring divider
// Revision: 1.0
// ============================================================================
module ceespu_muldiv #(
    parameter int WIDTH = 32
) (
    input  wire logic        I_clk,
    input  wire logic        I_rst,
    ceespu_muldiv_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_count;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_operand;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_result;
    logic             r_ready;

    // r_hi/r_lo hold {upper, multiplier} for MUL and {remainder, dividend} for DIV;
    // r_operand is the multiplicand or the divisor respectively.
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;
    logic [WIDTH:0]   w_shift;
    logic             w_borrow;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_div_hi;
    logic [WIDTH-1:0] w_div_lo;

    always_comb begin
        w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_operand} : {(WIDTH+1){1'b0}});
        w_mul_hi  = w_mul_sum[WIDTH:1];
        w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};

        w_shift   = {r_hi, r_lo[WIDTH-1]};
        w_borrow  = (w_shift < {1'b0, r_operand});
        // Without a borrow the difference fits WIDTH bits, so the top bit can be dropped.
        w_diff    = w_shift[WIDTH-1:0] - r_operand;
        w_div_hi  = w_borrow ? w_shift[WIDTH-1:0] : w_diff;
        w_div_lo  = {r_lo[WIDTH-2:0], ~w_borrow};
    end

    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.I_start) w_next = S_RUN;
            S_RUN:   if (r_count == '0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            r_count   <= '0;
            r_op      <= '0;
            r_operand <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_result  <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.I_start) begin
                        r_op      <= bus.I_op;
                        r_operand <= bus.I_op[1] ? bus.I_dataB : bus.I_dataA;
                        r_lo      <= bus.I_op[1] ? bus.I_dataA : bus.I_dataB;
                        r_hi      <= '0;
                        r_count   <= CW'(WIDTH - 1);
                    end
                end
                S_RUN: begin
                    if (r_op[1]) begin
                        r_hi <= w_div_hi;
                        r_lo <= w_div_lo;
                    end else begin
                        r_hi <= w_mul_hi;
                        r_lo <= w_mul_lo;
                    end
                    if (r_count != '0) r_count <= r_count - 1'b1;
                end
                S_DONE: begin
                    // MUL/DIVU take the low register, MULHU/REMU the high one.
                    r_result <= r_op[0] ? r_hi : r_lo;
                    r_ready  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.O_busy       = (r_state != S_IDLE);
    assign bus.O_dataReady  = r_ready;
    assign bus.O_dataResult = r_result;
endmodule
`default_nettype wire
